tc_rom_loader: RTL

Byte-stream writer for the TC memory port. Accepts a little-endian byte stream over a valid/ready handshake, packs it into `BIT_WIDTH` words and writes them to consecutive addresses from 0 through the memory's `save`/`address`/`in` port. It is the filling end of the memory interface: the write-side counterpart to the file-based ROM image load. It sits between a host/UART byte source and a TC_Rom/RAM-style memory instance.

---
 rtl/tc_rom_loader_pkg.sv | 17 +
 rtl/tc_byte_packer.sv | 46 ++++
 rtl/tc_rom_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/tc_rom_loader_pkg.sv
// Shared types for the TC memory byte-stream loader: FSM states, lane width, word sizing.
package tc_rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int LANE_W = 8;

  function automatic int bytes_per_word(input int width);
    return width / LANE_W;
  endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Packs little-endian bytes into one word; lane write lands on the next edge.
// No flow control of its own: the caller qualifies wr_en with its handshake.
module tc_byte_packer
  import tc_rom_loader_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [7:0]              byte_data,
  input  logic                    byte_last,
  output logic [LANE_W*BYTES-1:0] word,
  output logic                    word_end,
  output logic                    last_seen
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0] idx;
  logic             full;

  assign full     = (idx == IDX_W'(BYTES - 1));
  assign word_end = wr_en && (full || byte_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx       <= '0;
      word      <= '0;
      last_seen <= 1'b0;
    end else if (clr) begin
      idx       <= '0;
      word      <= '0;
      last_seen <= 1'b0;
    end else if (wr_en) begin
      word[int'(idx)*LANE_W +: LANE_W] <= byte_data;
      if (byte_last)
        last_seen <= 1'b1;
      // Index parks on the final lane; the WRITE-state clear rewinds it.
      if (!full && !byte_last)
        idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tc_rom_loader.sv
// Byte stream to memory word writer: one WRITE cycle after the last byte of each word, BYTES+1 cycles/word.
// byte_ready is decoded from state only; byte_valid gaps stall COLLECT, a full memory stops intake for good.
module tc_rom_loader
  import tc_rom_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int BIT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 byte_last,
  output logic                 byte_ready,
  output logic                 mem_save,
  output logic                 mem_load,
  output logic [15:0]          mem_address,
  output logic [BIT_WIDTH-1:0] mem_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          words_written
);

  localparam int          BYTES     = bytes_per_word(BIT_WIDTH);
  localparam logic [15:0] LAST_ADDR = 16'(BIT_DEPTH - 1);

  state_t                 state, state_nxt;
  logic [15:0]            addr;
  logic [15:0]            count;
  logic [BIT_WIDTH-1:0]   word;
  logic                   take, clr, word_end, last_seen, at_end, finish;

  assign take   = byte_valid && byte_ready;
  assign at_end = (addr == LAST_ADDR);
  assign finish = last_seen || at_end;
  assign clr    = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && !finish);

  tc_byte_packer #(
    .BYTES(BYTES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (take),
    .byte_data (byte_data),
    .byte_last (byte_last),
    .word      (word),
    .word_end  (word_end),
    .last_seen (last_seen)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start)    state_nxt = ST_COLLECT;
      ST_COLLECT: if (word_end) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = finish ? ST_DONE : ST_COLLECT;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_save   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE:    busy       = 1'b0;
      ST_COLLECT: byte_ready = 1'b1;
      ST_WRITE:   mem_save   = 1'b1;
      ST_DONE:    done       = 1'b1;
      default:    busy       = 1'b0;
    endcase
  end

  // Address and count survive DONE so the host can read back how far the load got.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr  <= '0;
      count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      addr  <= '0;
      count <= '0;
    end else if (state == ST_WRITE) begin
      count <= count + 16'd1;
      if (!finish)
        addr <= addr + 16'd1;
    end
  end

  assign mem_load      = 1'b0;
  assign mem_address   = addr;
  assign mem_in        = mem_save ? word : '0;
  assign words_written = count;

endmodule
